data_mem: RTL and testbench

- Byte-addressable 32-bit data memory for the processor datapath, sitting between the ALU address output and the register-file writeback mux.
- Synchronous word write and combinational word read, little-endian.
- Unaligned addresses are supported.
- Asynchronous active-low reset clears the whole array.

---
 rtl/data_mem.sv | 52 +++++
 tb/tb_data_mem.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/data_mem.sv
// Byte-addressable little-endian 32-bit data memory, unaligned accesses wrap modulo DEPTH_BYTES.
// Latency: read is combinational; a write lands on the rising clk edge. There is no backpressure.
module data_mem #(
    parameter int DEPTH_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wrt_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data
);

    localparam int ADDR_BITS = $clog2(DEPTH_BYTES);

    logic [7:0]           mem_q [DEPTH_BYTES];
    logic [7:0]           mem_d [DEPTH_BYTES];
    logic [ADDR_BITS-1:0] idx;
    logic                 unused_addr_hi;

    // Upper address bits alias onto the same storage.
    assign idx            = address[ADDR_BITS-1:0];
    assign unused_addr_hi = ^address[31:ADDR_BITS];

    // Index arithmetic is ADDR_BITS wide, so byte lanes past the top wrap to 0.
    always_comb begin
        mem_d = mem_q;
        if (wrt_en) begin
            for (int b = 0; b < 4; b++) begin
                mem_d[idx + ADDR_BITS'(b)] = write_data[8*b +: 8];
            end
        end
    end

    always_comb begin
        read_data = '0;
        for (int b = 0; b < 4; b++) begin
            read_data[8*b +: 8] = mem_q[idx + ADDR_BITS'(b)];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < DEPTH_BYTES; k++) begin
                mem_q[k] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: tb/tb_data_mem.sv
// Scoreboard bench for data_mem: expected words are queued as each read is driven, then popped and compared.
module tb_data_mem;

    localparam int DEPTH = 1024;

    logic        clk;
    logic        rst;
    logic        wrt_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;

    int          n_checks;
    int          n_errors;
    logic [31:0] sb_q [$];

    data_mem #(.DEPTH_BYTES(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .wrt_en     (wrt_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Present an address, queue its expected word, compare after the combinational settle.
    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        address = a;
        sb_q.push_back(exp);
        #1;
        chk(tag, read_data, sb_q.pop_front());
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        write_data = d;
        wrt_en     = 1'b1;
        @(negedge clk);
        wrt_en     = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst        = 1'b1;
        wrt_en     = 1'b0;
        address    = '0;
        write_data = '0;

        #1 rst = 1'b0;
        #2;
        rd("in_reset", 32'd44, 32'h0000_0000);
        #2 rst = 1'b1;

        @(negedge clk);
        rd("rst_rd22", 32'd22, 32'h0000_0000);
        rd("rst_rd44", 32'd44, 32'h0000_0000);
        rd("rst_rd0",  32'd0,  32'h0000_0000);

        wr(32'd44, 32'hAAAA_FFFF);
        rd("al_rd44", 32'd44, 32'hAAAA_FFFF);
        rd("al_rd22", 32'd22, 32'h0000_0000);
        rd("al_rd0",  32'd0,  32'h0000_0000);

        wr(32'd0, 32'h0000_0000);
        rd("zero_rd0",  32'd0,  32'h0000_0000);
        rd("zero_rd44", 32'd44, 32'hAAAA_FFFF);

        @(negedge clk);
        address    = 32'd44;
        write_data = 32'h1234_5678;
        wrt_en     = 1'b0;
        repeat (3) @(negedge clk);
        rd("gate_rd44", 32'd44, 32'hAAAA_FFFF);

        wr(32'd5, 32'h1122_3344);
        rd("ua_rd5", 32'd5, 32'h1122_3344);
        rd("ua_rd4", 32'd4, 32'h2233_4400);
        rd("ua_rd8", 32'd8, 32'h0000_0011);
        rd("alias",  32'(5 + DEPTH), 32'h1122_3344);

        wr(32'(DEPTH - 2), 32'hDEAD_BEEF);
        rd("wrap_top", 32'(DEPTH - 2), 32'hDEAD_BEEF);
        rd("wrap_rd0", 32'd0, 32'h0000_DEAD);

        wr(32'd300, 32'h0102_0304);
        wr(32'd302, 32'hA0B0_C0D0);
        rd("ovl_rd300", 32'd300, 32'hC0D0_0304);
        rd("ovl_rd304", 32'd304, 32'h0000_A0B0);

        // Read-during-write: old word before the edge, new word after it.
        @(negedge clk);
        write_data = 32'h5566_7788;
        wrt_en     = 1'b1;
        rd("rdw_before", 32'd100, 32'h0000_0000);
        @(posedge clk);
        #1;
        wrt_en = 1'b0;
        rd("rdw_after", 32'd100, 32'h5566_7788);

        // Only the address present at the edge is written.
        @(negedge clk);
        address    = 32'd200;
        write_data = 32'hCAFE_F00D;
        wrt_en     = 1'b1;
        #2 address = 32'd204;
        @(negedge clk);
        wrt_en = 1'b0;
        rd("edge_rd200", 32'd200, 32'h0000_0000);
        rd("edge_rd204", 32'd204, 32'hCAFE_F00D);

        // Asynchronous reset between edges while a write is pending.
        @(negedge clk);
        address    = 32'd44;
        write_data = 32'hFFFF_FFFF;
        wrt_en     = 1'b1;
        #2 rst = 1'b0;
        rd("arst_noclk", 32'd44, 32'h0000_0000);
        @(posedge clk);
        #1;
        rd("arst_hold", 32'd44, 32'h0000_0000);
        @(negedge clk);
        wrt_en = 1'b0;
        rst    = 1'b1;
        rd("post_rd44",  32'd44, 32'h0000_0000);
        rd("post_rd5",   32'd5,  32'h0000_0000);
        rd("post_rd204", 32'd204, 32'h0000_0000);
        rd("post_wrap",  32'(DEPTH - 2), 32'h0000_0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
